usb_nrzi_rx: RTL and testbench
==============================

USB_NRZI_RX -- requirements
Module: usb_nrzi_rx

Interface
REQ-001 SHALL have one clock, clk, and an asynchronous, active-low reset, rst_b.
REQ-002 Parameter: STUFF_LIMIT, default 6, number of consecutive decoded 1s after which a stuffed 0 is expected.
REQ-003 clk  input  1  rising-edge clock; at most one line sample per cycle.
REQ-004 rst_b  input  1  asynchronous active-low reset.
REQ-005 en  input  1  sample enable; when low, all state and outputs hold, except that the pulse outputs drop to 0.
REQ-006 dp, dm  input  1 each  bus lines: J = {dp,dm} 10, K = 01, SE0 = 00, SE1 = 11.
REQ-007 bit_out  output  1  decoded, unstuffed data bit, valid when bit_avail is high.
REQ-008 bit_avail  output  1  one-cycle strobe per delivered data bit.
REQ-009 pkt_start  output  1  one-cycle pulse when a SYNC is accepted.
REQ-010 pkt_end  output  1  one-cycle pulse when a valid EOP completes.
REQ-011 rx_err  output  1  one-cycle pulse on a stuff, EOP or SE1 error.
REQ-012 bit_cnt  output  7  count of data bits delivered in the current packet; saturates at 127.
REQ-013 timeout  output  1  one-cycle pulse when a packet is aborted for length (see REQ-030).

Function
REQ-014 All outputs SHALL be registered; each response appears one cycle after the enabled sample that causes it.
REQ-015 Register prev_line, reset J, SHALL update to the current J/K line state on every enabled sample.
REQ-016 NRZI decode SHALL be: line equal to prev_line gives decoded 1; line different from prev_line gives decoded 0.
REQ-017 States SHALL be IDLE, SYNC, DATA, EOP and ERR_WAIT.
REQ-018 IDLE: J holds IDLE; K counts as decoded 0 number one and moves to SYNC; SE0 or SE1 holds IDLE.
REQ-019 SYNC: each decoded 0 increments zero_cnt.
- A decoded 1 with zero_cnt == 7 moves to DATA, pulses pkt_start and clears bit_cnt and ones_cnt.
- A decoded 1 with fewer zeros, an 8th zero, or SE0 returns to IDLE silently.
REQ-020 DATA, J/K sample with ones_cnt < STUFF_LIMIT: drive bit_out = decoded bit and pulse bit_avail.
- Decoded 1 increments ones_cnt; decoded 0 clears it.
- bit_cnt increments, saturating at 127.
REQ-021 DATA, J/K sample with ones_cnt == STUFF_LIMIT:
- Decoded 0 is a stuffed bit: drop it (no bit_avail), clear ones_cnt, leave bit_cnt unchanged.
- Decoded 1 pulses rx_err and moves to ERR_WAIT.
REQ-022 DATA, SE0 moves to EOP with se0_cnt = 1 and delivers no bit.
REQ-023 EOP: SE0 increments se0_cnt, saturating at 3.
- J with se0_cnt >= 2 pulses pkt_end and moves to IDLE.
- J with se0_cnt == 1, or K, pulses rx_err and moves to ERR_WAIT.
REQ-024 SE1 in SYNC, DATA or EOP SHALL pulse rx_err and move to ERR_WAIT.
REQ-025 ERR_WAIT SHALL drive no data or pulses until an SE0 followed by J is seen, then move to IDLE.
REQ-026 prev_line SHALL be set to J on every entry to IDLE, so the first K after idle always decodes as 0.
REQ-027 bit_cnt SHALL hold its final value after pkt_end or rx_err until the next pkt_start.

Reset
REQ-028 Asserting rst_b low SHALL immediately force IDLE, prev_line = J, all counters to 0 and all outputs to 0, including mid-packet.
REQ-029 After reset is released, the first enabled sample SHALL be processed normally.

Configuration
REQ-030 With USB_RX_TIMEOUT_EN defined, a 8-bit counter SHALL count enabled cycles spent in SYNC, DATA or EOP.
- On reaching 255, pulse timeout and rx_err, then move to ERR_WAIT.
- The counter clears on entry to IDLE.
- Without the macro, timeout is tied to 0 and no counter exists; the port is present in both builds.

Verification
REQ-031 Idle J, then KJKJKJKK, then NRZI of 0x87 (LSB first), then SE0, SE0, J -> pkt_start; 8 bit_avail strobes with bits 1,1,1,0,0,0,0,1; bit_cnt = 8; pkt_end.
REQ-032 After SYNC, send seven decoded 1s (STUFF_LIMIT = 6) -> 6 strobes, then rx_err, ERR_WAIT; SE0, J -> IDLE.
REQ-033 After SYNC, six 1s, a stuffed 0, then 1 -> 7 strobes total, all bit_out = 1, bit_cnt = 7, no rx_err.
REQ-034 SYNC KJKJKK (only 5 zeros) -> no pkt_start, return to IDLE; a following full SYNC is accepted.
REQ-035 Single SE0 then J ending a packet -> rx_err, no pkt_end; rst_b pulsed low mid-DATA -> all outputs 0 in the same cycle, state IDLE.
REQ-036 With USB_RX_TIMEOUT_EN: after SYNC, 300 cycles of alternating data with no EOP -> timeout and rx_err at enabled cycle 255; without the macro -> timeout stays 0.

Source files
------------

// File: rtl/usb_nrzi_rx.sv
// usb_nrzi_rx: USB full-speed receive front end.
// Samples the dp/dm line pair, NRZI-decodes J/K symbols, detects SYNC,
// removes stuffed bits, recognises EOP and flags line/stuff errors.
// Optional build macro: USB_RX_TIMEOUT_EN adds an 8-bit length watchdog
// that aborts a packet after 255 enabled cycles in SYNC/DATA/EOP.
//
// Handshake: there is no backpressure. bit_avail is a one-cycle strobe that
// qualifies bit_out; pkt_start, pkt_end, rx_err and timeout are one-cycle
// pulses. Every output is registered and reflects the enabled sample taken
// on the previous rising edge. With en low nothing advances and all pulses
// read 0 on the next cycle.
module usb_nrzi_rx #(
    parameter int STUFF_LIMIT = 6
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       en,
    input  logic       dp,
    input  logic       dm,
    output logic       bit_out,
    output logic       bit_avail,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       rx_err,
    output logic [6:0] bit_cnt,
    output logic       timeout,
    output logic [2:0] dbg_state
);

    localparam int OW = (STUFF_LIMIT < 1) ? 1 : $clog2(STUFF_LIMIT + 1);
    localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA     = 3'd2,
        ST_EOP      = 3'd3,
        ST_ERR_WAIT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            prev_line_q, prev_line_d;   // 1 = J, 0 = K
    logic [2:0]      zero_cnt_q, zero_cnt_d;
    logic [OW-1:0]   ones_cnt_q, ones_cnt_d;
    logic [1:0]      se0_cnt_q, se0_cnt_d;
    logic            seen_se0_q, seen_se0_d;
    logic [6:0]      bit_cnt_q, bit_cnt_d;
    logic            bit_out_q, bit_out_d;
    logic            bit_avail_q, bit_avail_d;
    logic            pkt_start_q, pkt_start_d;
    logic            pkt_end_q, pkt_end_d;
    logic            rx_err_q, rx_err_d;
    logic            go_err;

`ifdef USB_RX_TIMEOUT_EN
    logic [7:0]      tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // Line symbol classification; dp alone distinguishes J from K.
    logic is_j, is_k, is_se0, is_se1, dec_one;
    assign is_j    = dp & ~dm;
    assign is_k    = ~dp & dm;
    assign is_se0  = ~dp & ~dm;
    assign is_se1  = dp & dm;
    assign dec_one = (dp == prev_line_q);

    // Next-state and output decode for one enabled line sample.
    always_comb begin
        state_d     = state_q;
        prev_line_d = prev_line_q;
        zero_cnt_d  = zero_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        se0_cnt_d   = se0_cnt_q;
        seen_se0_d  = seen_se0_q;
        bit_cnt_d   = bit_cnt_q;
        bit_out_d   = bit_out_q;
        bit_avail_d = 1'b0;
        pkt_start_d = 1'b0;
        pkt_end_d   = 1'b0;
        rx_err_d    = 1'b0;
        go_err      = 1'b0;
`ifdef USB_RX_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif

        if (en) begin
            if (is_j || is_k) begin
                prev_line_d = dp;
            end

            case (state_q)
                ST_IDLE: begin
                    // First K after idle is SYNC zero number one.
                    if (is_k) begin
                        state_d    = ST_SYNC;
                        zero_cnt_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (is_se1) begin
                        go_err = 1'b1;
                    end else if (is_se0) begin
                        state_d = ST_IDLE;
                    end else if (dec_one) begin
                        if (zero_cnt_q == 3'd7) begin
                            state_d     = ST_DATA;
                            pkt_start_d = 1'b1;
                            bit_cnt_d   = 7'd0;
                            ones_cnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (zero_cnt_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end else begin
                        zero_cnt_d = zero_cnt_q + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (is_se1) begin
                        go_err = 1'b1;
                    end else if (is_se0) begin
                        state_d   = ST_EOP;
                        se0_cnt_d = 2'd1;
                    end else if (ones_cnt_q == STUFF_MAX) begin
                        // A run of STUFF_LIMIT ones must be followed by a stuffed 0.
                        if (dec_one) begin
                            go_err = 1'b1;
                        end else begin
                            ones_cnt_d = '0;
                        end
                    end else begin
                        bit_out_d   = dec_one;
                        bit_avail_d = 1'b1;
                        ones_cnt_d  = dec_one ? (ones_cnt_q + 1'b1) : '0;
                        if (bit_cnt_q != 7'd127) begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end
                end
                ST_EOP: begin
                    if (is_se1 || is_k) begin
                        go_err = 1'b1;
                    end else if (is_se0) begin
                        if (se0_cnt_q != 2'd3) begin
                            se0_cnt_d = se0_cnt_q + 2'd1;
                        end
                    end else if (se0_cnt_q >= 2'd2) begin
                        state_d   = ST_IDLE;
                        pkt_end_d = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                ST_ERR_WAIT: begin
                    // Recover only on SE0 immediately followed by J.
                    if (is_se0) begin
                        seen_se0_d = 1'b1;
                    end else if (is_j && seen_se0_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        seen_se0_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

`ifdef USB_RX_TIMEOUT_EN
            if (state_q == ST_SYNC || state_q == ST_DATA || state_q == ST_EOP) begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (tmo_cnt_q == 8'd254) begin
                    // Length abort overrides whatever this sample would have done.
                    timeout_d   = 1'b1;
                    go_err      = 1'b1;
                    bit_avail_d = 1'b0;
                    pkt_start_d = 1'b0;
                    pkt_end_d   = 1'b0;
                    bit_out_d   = bit_out_q;
                    bit_cnt_d   = bit_cnt_q;
                end
            end
`endif

            if (go_err) begin
                state_d    = ST_ERR_WAIT;
                rx_err_d   = 1'b1;
                seen_se0_d = 1'b0;
            end

            // Entering IDLE re-arms the decoder so the next K decodes as 0.
            if (state_d == ST_IDLE) begin
                prev_line_d = 1'b1;
`ifdef USB_RX_TIMEOUT_EN
                tmo_cnt_d   = 8'd0;
`endif
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            prev_line_q <= 1'b1;
            zero_cnt_q  <= 3'd0;
            ones_cnt_q  <= '0;
            se0_cnt_q   <= 2'd0;
            seen_se0_q  <= 1'b0;
            bit_cnt_q   <= 7'd0;
            bit_out_q   <= 1'b0;
            bit_avail_q <= 1'b0;
            pkt_start_q <= 1'b0;
            pkt_end_q   <= 1'b0;
            rx_err_q    <= 1'b0;
`ifdef USB_RX_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_line_q <= prev_line_d;
            zero_cnt_q  <= zero_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            se0_cnt_q   <= se0_cnt_d;
            seen_se0_q  <= seen_se0_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_out_q   <= bit_out_d;
            bit_avail_q <= bit_avail_d;
            pkt_start_q <= pkt_start_d;
            pkt_end_q   <= pkt_end_d;
            rx_err_q    <= rx_err_d;
`ifdef USB_RX_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_avail = bit_avail_q;
    assign pkt_start = pkt_start_q;
    assign pkt_end   = pkt_end_q;
    assign rx_err    = rx_err_q;
    assign bit_cnt   = bit_cnt_q;
    assign dbg_state = state_q;
`ifdef USB_RX_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_usb_nrzi_rx.sv
// Directed testbench for usb_nrzi_rx: hand-built line sequences with
// hand-computed expected bits, pulses, counts and states.
module tb_usb_nrzi_rx;

  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] L_K   = 2'b01;
  localparam logic [1:0] L_SE0 = 2'b00;
  localparam logic [1:0] L_SE1 = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_EOP  = 3'd3;
  localparam logic [2:0] S_ERRW = 3'd4;

  logic       clk;
  logic       rst_b;
  logic       en;
  logic       dp;
  logic       dm;
  logic       bit_out;
  logic       bit_avail;
  logic       pkt_start;
  logic       pkt_end;
  logic       rx_err;
  logic [6:0] bit_cnt;
  logic       timeout;
  logic [2:0] dbg_state;

  int n_vec;
  int n_miss;

  // capture of observed strobes/pulses since the last clear
  logic [0:0] got_q[$];
  logic [0:0] exp_q[$];
  int cap_avail;
  int cap_start;
  int cap_end;
  int cap_err;
  int cap_tmo;
  logic tx_lvl;  // 1 = J, bench-side NRZI encoder level

  usb_nrzi_rx #(.STUFF_LIMIT(6)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .en        (en),
    .dp        (dp),
    .dm        (dm),
    .bit_out   (bit_out),
    .bit_avail (bit_avail),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .rx_err    (rx_err),
    .bit_cnt   (bit_cnt),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_cap();
    got_q.delete();
    exp_q.delete();
    cap_avail = 0;
    cap_start = 0;
    cap_end   = 0;
    cap_err   = 0;
    cap_tmo   = 0;
  endtask

  // driver: apply one line symbol, let the DUT sample it, capture the response
  task automatic drive(input logic [1:0] l);
    {dp, dm} = l;
    @(posedge clk);
    #1;
    if (en) begin
      if (bit_avail) begin
        got_q.push_back(bit_out);
        cap_avail++;
      end
      if (pkt_start) cap_start++;
      if (pkt_end)   cap_end++;
      if (rx_err)    cap_err++;
      if (timeout)   cap_tmo++;
    end
  endtask

  task automatic send_sync();
    drive(L_K); drive(L_J); drive(L_K); drive(L_J);
    drive(L_K); drive(L_J); drive(L_K); drive(L_K);
    tx_lvl = 1'b0;
  endtask

  task automatic send_dec(input logic b);
    if (!b) tx_lvl = ~tx_lvl;
    drive(tx_lvl ? L_J : L_K);
  endtask

  task automatic check_bits(input string tag);
    chk({tag, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int tmo_at;
    logic [7:0] pid;
    n_vec  = 0;
    n_miss = 0;
    en     = 1'b1;
    {dp, dm} = L_J;
    tx_lvl = 1'b1;
    clear_cap();
    rst_b  = 1'b0;
    #3;
    chk("rst_avail", bit_avail, 0);
    chk("rst_out",   bit_out, 0);
    chk("rst_start", pkt_start, 0);
    chk("rst_end",   pkt_end, 0);
    chk("rst_err",   rx_err, 0);
    chk("rst_cnt",   bit_cnt, 0);
    chk("rst_tmo",   timeout, 0);
    chk("rst_state", dbg_state, S_IDLE);
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;

    // good packet carrying 0x87, LSB first
    drive(L_J); drive(L_J);
    clear_cap();
    send_sync();
    chk("p1_start_pulse", pkt_start, 1);
    chk("p1_state_data", dbg_state, S_DATA);
    pid = 8'h87;
    for (int i = 0; i < 8; i++) begin
      send_dec(pid[i]);
      exp_q.push_back(pid[i]);
    end
    drive(L_SE0);
    chk("p1_state_eop", dbg_state, S_EOP);
    drive(L_SE0);
    drive(L_J);
    chk("p1_end_pulse", pkt_end, 1);
    drive(L_J);
    chk("p1_end_one_cycle", pkt_end, 0);
    check_bits("p1");
    chk("p1_cnt", bit_cnt, 8);
    chk("p1_nstart", cap_start, 1);
    chk("p1_nend", cap_end, 1);
    chk("p1_nerr", cap_err, 0);
    chk("p1_state_idle", dbg_state, S_IDLE);

    // seven ones: sixth run bit then a missing stuff bit
    clear_cap();
    send_sync();
    for (int i = 0; i < 7; i++) begin
      send_dec(1'b1);
      if (i < 6) exp_q.push_back(1'b1);
    end
    chk("p2_err_pulse", rx_err, 1);
    chk("p2_state_errw", dbg_state, S_ERRW);
    check_bits("p2");
    chk("p2_cnt_hold", bit_cnt, 6);
    drive(L_J);
    chk("p2_j_alone_stays", dbg_state, S_ERRW);
    drive(L_SE0);
    drive(L_J);
    chk("p2_recover", dbg_state, S_IDLE);
    chk("p2_nerr", cap_err, 1);

    // six ones, stuffed zero, then one more one
    clear_cap();
    send_sync();
    for (int i = 0; i < 6; i++) begin
      send_dec(1'b1);
      exp_q.push_back(1'b1);
    end
    send_dec(1'b0);
    chk("p3_stuff_no_avail", bit_avail, 0);
    send_dec(1'b1);
    exp_q.push_back(1'b1);
    check_bits("p3");
    chk("p3_cnt", bit_cnt, 7);
    drive(L_SE0); drive(L_SE0); drive(L_J);
    chk("p3_nerr", cap_err, 0);
    chk("p3_nend", cap_end, 1);
    drive(L_J);
    chk("p3_cnt_hold", bit_cnt, 7);

    // short SYNC, then a full SYNC, then a single-SE0 EOP
    clear_cap();
    drive(L_K); drive(L_J); drive(L_K); drive(L_J); drive(L_K); drive(L_K);
    chk("p4_short_idle", dbg_state, S_IDLE);
    chk("p4_short_nstart", cap_start, 0);
    drive(L_J);
    send_sync();
    chk("p4_full_start", pkt_start, 1);
    send_dec(1'b0);
    drive(L_SE0);
    drive(L_J);
    chk("p4_eop_err", rx_err, 1);
    chk("p4_eop_noend", cap_end, 0);
    chk("p4_eop_errw", dbg_state, S_ERRW);
    drive(L_SE0); drive(L_J);

    // SE1 inside DATA
    send_sync();
    send_dec(1'b0);
    drive(L_SE1);
    chk("p5_se1_err", rx_err, 1);
    chk("p5_se1_errw", dbg_state, S_ERRW);
    drive(L_SE0); drive(L_J);

    // sample enable low: state holds, pulses drop
    clear_cap();
    send_sync();
    en = 1'b0;
    drive(L_J);
    chk("p6_en_start_drop", pkt_start, 0);
    chk("p6_en_hold_state", dbg_state, S_DATA);
    drive(L_SE1);
    chk("p6_en_no_err", rx_err, 0);
    chk("p6_en_cnt", bit_cnt, 0);
    en = 1'b1;
    send_dec(1'b1);
    chk("p6_bit_avail", bit_avail, 1);
    chk("p6_bit_val", bit_out, 1);
    chk("p6_cnt1", bit_cnt, 1);

    // asynchronous reset in the middle of DATA
    #2;
    rst_b = 1'b0;
    #1;
    chk("p7_rst_avail", bit_avail, 0);
    chk("p7_rst_out", bit_out, 0);
    chk("p7_rst_cnt", bit_cnt, 0);
    chk("p7_rst_state", dbg_state, S_IDLE);
    @(posedge clk); #1;
    rst_b = 1'b1;
    drive(L_K);
    chk("p7_first_sample", dbg_state, S_SYNC);
    drive(L_SE0);
    chk("p7_sync_se0_idle", dbg_state, S_IDLE);

    // long packet: 300 alternating symbols with no EOP
    clear_cap();
    drive(L_J);
    send_sync();
    tmo_at = 0;
    for (int i = 1; i <= 300; i++) begin
      send_dec(1'b0);
      if (timeout && tmo_at == 0) tmo_at = i;
    end
`ifdef USB_RX_TIMEOUT_EN
    // 7 SYNC samples are counted before DATA, so sample 248 is the 255th
    chk("p8_tmo_at", tmo_at, 248);
    chk("p8_tmo_n", cap_tmo, 1);
    chk("p8_tmo_err", cap_err, 1);
    chk("p8_tmo_avail", cap_avail, 247);
    chk("p8_tmo_state", dbg_state, S_ERRW);
    chk("p8_tmo_cnt", bit_cnt, 127);
    drive(L_SE0); drive(L_J);
`else
    chk("p8_no_tmo", cap_tmo, 0);
    chk("p8_no_tmo_at", tmo_at, 0);
    chk("p8_no_err", cap_err, 0);
    chk("p8_avail", cap_avail, 300);
    chk("p8_cnt_sat", bit_cnt, 127);
    chk("p8_state", dbg_state, S_DATA);
    drive(L_SE0); drive(L_SE0); drive(L_J);
    chk("p8_end", cap_end, 1);
`endif
    chk("p8_idle", dbg_state, S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // hard stop so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
